// File: rtl/dec_pkg.sv
// Shared types and constants for the decimal digit assembler.
package dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } dec_state_t;

  localparam int DEC_BASE      = 10;
  localparam int DEC_MAX_DIGIT = 9;
  localparam int DEC_DIGIT_W   = 4;

endpackage

// File: rtl/dec_mul10_add.sv
// Combinational acc*10 + digit with overflow saturation.
module dec_mul10_add
  import dec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]       acc,
  input  logic [DEC_DIGIT_W-1:0] digit,
  output logic [WIDTH-1:0]       sum,
  output logic                   ovf
);

  logic [WIDTH+3:0] w_ext;
  logic [WIDTH+3:0] w_prod;

  assign w_ext  = {4'b0000, acc};
  // x*10 as x*8 + x*2; four spare bits hold any carry
  assign w_prod = (w_ext << 3) + (w_ext << 1)
                + {{WIDTH{1'b0}}, digit};

  assign ovf = |w_prod[WIDTH+3:WIDTH];
  assign sum = ovf ? '1 : w_prod[WIDTH-1:0];

endmodule

// File: rtl/dec_digit_assembler.sv
// Decimal digit stream to binary number assembler.
// Build option: DEC_DIGIT_CHECK_EN flags and zeroes digits above 9.
module dec_digit_assembler
  import dec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   digit_valid,
  input  logic [DEC_DIGIT_W-1:0] digit,
  input  logic                   digit_last,
  output logic                   digit_ready,
  output logic [WIDTH-1:0]       number,
  output logic                   number_valid,
  input  logic                   number_ready,
  output logic [CNT_W-1:0]       digit_count,
  output logic                   overflow,
  output logic                   err
);

  dec_state_t r_state;
  dec_state_t w_next;

  logic [WIDTH-1:0]       r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_take;
  logic                   w_first;
  logic                   w_bad;
  logic [DEC_DIGIT_W-1:0] w_dig;
  logic [WIDTH-1:0]       w_base;
  logic [WIDTH-1:0]       w_sum;
  logic                   w_ovf;
  logic                   w_ovf_keep;
  logic                   w_err_keep;

  assign digit_ready  = (r_state != HOLD) && !rst;
  assign number_valid = (r_state == HOLD);
  assign w_accept     = digit_valid && digit_ready;
  assign w_take       = number_valid && number_ready;
  assign w_first      = (r_state == IDLE);

`ifdef DEC_DIGIT_CHECK_EN
  assign w_bad = (digit > DEC_DIGIT_W'(DEC_MAX_DIGIT));
`else
  assign w_bad = 1'b0;
`endif

  assign w_dig  = w_bad ? '0 : digit;
  // a new frame starts from zero, so acc <- digit
  assign w_base = w_first ? '0 : r_acc;

  dec_mul10_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .acc   (w_base),
    .digit (w_dig),
    .sum   (w_sum),
    .ovf   (w_ovf)
  );

  assign w_ovf_keep = r_ovf && !w_first;
  assign w_err_keep = r_err && !w_first;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, ACCUM: begin
        if (w_accept)
          w_next = digit_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (w_take)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= (w_ovf_keep || w_ovf) ? '1 : w_sum;
        r_ovf <= w_ovf_keep || w_ovf;
        r_err <= w_err_keep || w_bad;
        if (w_first)
          r_cnt <= CNT_W'(1);
        else if (!(&r_cnt))
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign number      = r_acc;
  assign digit_count = r_cnt;
  assign overflow    = r_ovf;
  assign err         = r_err;

endmodule

// File: doc/dec_digit_assembler.md
# dec_digit_assembler

Upstream feeder for the decimal palindrome checker. Accepts a stream of decimal digits, most significant first, one per cycle over a valid/ready handshake. Accumulates them into a binary integer and presents the completed number on a held valid/ready output. The number output drives the palindrome checker's `number` input directly.

## Interface
- `WIDTH`, 16: width of the assembled binary number; matches the checker's `WIDTH`.
- `CNT_W`, 4: width of the digit counter; saturates at 2^CNT_W-1.

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `digit_valid`  in  1: a digit is offered.
- `digit`  in  4: digit value; legal values are 0–9.
- `digit_last`  in  1: the offered digit is the final one of its frame.
- `digit_ready`  out  1: the block can accept a digit.
- `number`  out  WIDTH: assembled value; stable while `number_valid` is high.
- `number_valid`  out  1: a completed frame is being presented.
- `number_ready`  in  1: the downstream stage takes the frame.
- `digit_count`  out  CNT_W: digits in the presented frame, saturating.
- `overflow`  out  1: the frame's value exceeded 2^WIDTH-1.
- `err`  out  1: the frame contained an illegal digit (see Configuration).

## Operation
- FSM states:
  - IDLE: no digit accepted yet in the current frame.
  - ACCUM: at least one digit accepted, last not yet seen.
  - HOLD: completed frame is presented.
- `digit_ready` = (state != HOLD) && !rst. It is combinational from the state.
- Accept = `digit_valid && digit_ready`.
- IDLE, on accept: acc ← digit, count ← 1, flags cleared and then set from this digit. Next state is HOLD if `digit_last`, else ACCUM.
- ACCUM, on accept: acc ← acc*10 + digit, count ← count+1 (saturating). Next state is HOLD if `digit_last`.
- Arithmetic:
  - The product is formed in WIDTH+4 bits as (acc<<3)+(acc<<1)+digit.
  - If any bit above WIDTH-1 is set, acc ← all-ones and `overflow` sets.
  - Once set, acc stays at all-ones for the rest of the frame and `overflow` is sticky until the frame is consumed.
- Leading zeros are accepted and counted; they do not change the value.
- HOLD:
  - `number`, `digit_count`, `overflow` and `err` are held stable.
  - On `number_valid && number_ready` the block returns to IDLE, and all four outputs keep their values until the next frame's first accept.
- `digit_valid` low in IDLE/ACCUM means the block waits; no timeout.
- `digit_last` is ignored when `digit_valid` is low.

## Timing
- Reset values: state IDLE, `number`=0, `number_valid`=0, `digit_count`=0, `overflow`=0, `err`=0. `digit_ready` is 0 while `rst`=1 and 1 in the first cycle after.
- Throughput: one digit per cycle.
- Latency: `number_valid` rises in the cycle after the `digit_last` accept.
- Minimum frame period is N+1 cycles for N digits. `digit_ready` is low during the handshake cycle and returns high the cycle after.
- Simultaneous events: `number_valid && number_ready` in the same cycle as an offered digit means the digit is not accepted (`digit_ready`=0 in HOLD).
- Reset mid-frame discards the partial accumulation and forces the full reset state in the next cycle. `rst` has priority over every handshake.
- `digit_count` saturates at 2^CNT_W-1 and never wraps.

## Configuration
- Macro: `DEC_DIGIT_CHECK_EN`.
- Defined:
  - A digit of 10–15 sets `err` (sticky per frame) and contributes 0 to the accumulation.
  - The digit is still counted, and the frame completes normally.
- Undefined:
  - No check is made; `err` is tied 0.
  - The raw 4-bit value is added as given, e.g. 12 contributes 12.

## Structure
- Shared package `dec_pkg` holds:
  - state enum {IDLE, ACCUM, HOLD};
  - `DEC_BASE`=10;
  - `DEC_MAX_DIGIT`=9;
  - `DEC_DIGIT_W`=4.
- One sub-module, `dec_mul10_add`:
  - combinational;
  - inputs acc[WIDTH-1:0] and digit[3:0];
  - outputs sum[WIDTH-1:0] and ovf.
- FSM, registers and flags live in the top level.

## Test plan
- Digits 1,2,1 (last on the third) with `number_ready`=1 → `number`=121, `digit_count`=3, `overflow`=0, `number_valid` high the cycle after the third accept for exactly one cycle.
- WIDTH=16, digits 7,0,0,0,0 → `number`=65535, `overflow`=1. Then frame 5 (last) → `number`=5, `overflow`=0.
- Frame 4,4 with `number_ready` held low for 5 cycles → `number`=44 is stable, `digit_ready`=0 throughout, and the offered digit 9 is not accepted until the cycle after the handshake.
- Single digit 0 with `digit_last` → `number`=0, `digit_count`=1. Leading zeros 0,0,3 → `number`=3, `digit_count`=3.
- Digits 1,12,1:
  - with `DEC_DIGIT_CHECK_EN` → `err`=1, `number`=101;
  - without it → `err`=0, `number`=221.
- `rst` pulsed after digits 9,8 mid-frame → next cycle all outputs 0 and state IDLE; frame 6 (last) → `number`=6, `digit_count`=1.
